// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared types and constants for the dual-port clearable RAM
package dp_ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage

// File: rtl/dp_ram_clr_if.sv
// rtl/dp_ram_clr_if.sv - port A/B access, clear request and status bundle
interface dp_ram_clr_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 256,
    parameter int LANE_W = 8
);
    localparam int AW = $clog2(DEPTH);
    localparam int NL = WIDTH / LANE_W;

    logic             init;
    logic             busy;
    logic             collide;
    logic [AW-1:0]    addr_a;
    logic [AW-1:0]    addr_b;
    logic             en_a;
    logic             en_b;
    logic [NL-1:0]    be_a;
    logic [NL-1:0]    be_b;
    logic [WIDTH-1:0] d_a;
    logic [WIDTH-1:0] d_b;
    logic [WIDTH-1:0] q_a;
    logic [WIDTH-1:0] q_b;

    modport master (
        output init, addr_a, addr_b, en_a, en_b, be_a, be_b, d_a, d_b,
        input  busy, collide, q_a, q_b
    );

    modport slave (
        input  init, addr_a, addr_b, en_a, en_b, be_a, be_b, d_a, d_b,
        output busy, collide, q_a, q_b
    );

endinterface

// File: rtl/dp_ram_clr_seq.sv
// rtl/dp_ram_clr_seq.sv - clear sequencer: walks every address once after reset or init
module dp_ram_clr_seq
    import dp_ram_pkg::*;
#(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    output logic          busy,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // init while already clearing is deliberately ignored
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (init) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = (state == CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/dp_ram_clr.sv
// rtl/dp_ram_clr.sv - dual-port byte-lane RAM with self-clear; DP_RAM_CLR_OUTREG_EN adds an output stage
module dp_ram_clr #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 256,
    parameter int               LANE_W   = 8,
    parameter int               RDW_NEW  = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input logic         clk,
    input logic         rst_n,
    dp_ram_clr_if.slave bus
);

    localparam int            AW       = $clog2(DEPTH);
    localparam int            NL       = WIDTH / LANE_W;
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam bit            NEW_DATA = (RDW_NEW == dp_ram_pkg::RDW_NEW);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             busy;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             in_a, in_b;
    logic [NL-1:0]    lw_a, lw_b;
    logic [WIDTH-1:0] rd_a, rd_b, mrg_a, mrg_b;
    logic [WIDTH-1:0] q1_a, q1_b;
    logic             coll_nxt, coll1;

    dp_ram_clr_seq #(.DEPTH(DEPTH)) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (bus.init),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    assign bus.busy = busy;

    assign in_a = ({1'b0, bus.addr_a} < DEPTH_W);
    assign in_b = ({1'b0, bus.addr_b} < DEPTH_W);
    assign lw_a = (bus.en_a && in_a && !busy) ? bus.be_a : '0;
    assign lw_b = (bus.en_b && in_b && !busy) ? bus.be_b : '0;

    assign coll_nxt = (bus.addr_a == bus.addr_b) && ((lw_a & lw_b) != '0);

    // A is written after B so it wins on lanes both ports enable
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else begin
            for (int i = 0; i < NL; i++) begin
                if (lw_b[i]) mem[bus.addr_b][i*LANE_W +: LANE_W] <= bus.d_b[i*LANE_W +: LANE_W];
                if (lw_a[i]) mem[bus.addr_a][i*LANE_W +: LANE_W] <= bus.d_a[i*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        rd_a  = in_a ? mem[bus.addr_a] : '0;
        mrg_a = rd_a;
        for (int i = 0; i < NL; i++) begin
            if (lw_a[i]) mrg_a[i*LANE_W +: LANE_W] = bus.d_a[i*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        rd_b  = in_b ? mem[bus.addr_b] : '0;
        mrg_b = rd_b;
        for (int i = 0; i < NL; i++) begin
            if (lw_b[i]) mrg_b[i*LANE_W +: LANE_W] = bus.d_b[i*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a  <= '0;
            q1_b  <= '0;
            coll1 <= 1'b0;
        end else begin
            q1_a  <= NEW_DATA ? mrg_a : rd_a;
            q1_b  <= NEW_DATA ? mrg_b : rd_b;
            coll1 <= coll_nxt;
        end
    end

`ifdef DP_RAM_CLR_OUTREG_EN
    logic [WIDTH-1:0] q2_a, q2_b;
    logic             coll2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q2_a  <= '0;
            q2_b  <= '0;
            coll2 <= 1'b0;
        end else begin
            q2_a  <= q1_a;
            q2_b  <= q1_b;
            coll2 <= coll1;
        end
    end

    assign bus.q_a     = q2_a;
    assign bus.q_b     = q2_b;
    assign bus.collide = coll2;
`else
    assign bus.q_a     = q1_a;
    assign bus.q_b     = q1_b;
    assign bus.collide = coll1;
`endif

endmodule

// File: tb/tb_dp_ram_clr.sv
// tb/tb_dp_ram_clr.sv - scoreboard bench for dp_ram_clr
module tb_dp_ram_clr;

    localparam int          WIDTH    = 16;
    localparam int          DEPTH    = 16;
    localparam int          LANE_W   = 8;
    localparam int          RDW_NEW  = 0;
    localparam logic [15:0] INIT_VAL = 16'h00A5;
`ifdef DP_RAM_CLR_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        int          kind;
        logic [15:0] exp;
        int          tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dp_ram_clr_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANE_W(LANE_W)) bus ();

    dp_ram_clr #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .LANE_W   (LANE_W),
        .RDW_NEW  (RDW_NEW),
        .INIT_VAL (INIT_VAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // kind 0 = q_a, 1 = q_b, 2 = collide; due is the cycle the result appears
    task automatic expect_out(input int kind, input logic [15:0] v, input int tag);
        exp_t e;
        e.due  = cyc + LAT;
        e.kind = kind;
        e.exp  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ea, input logic [3:0] aa, input logic [15:0] da, input logic [1:0] ba,
                         input logic eb, input logic [3:0] ab, input logic [15:0] db, input logic [1:0] bb);
        bus.en_a = ea; bus.addr_a = aa; bus.d_a = da; bus.be_a = ba;
        bus.en_b = eb; bus.addr_b = ab; bus.d_b = db; bus.be_b = bb;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                case (e.kind)
                    0:       check($sformatf("q_a#%0d", e.tag), {16'h0, bus.q_a}, {16'h0, e.exp});
                    1:       check($sformatf("q_b#%0d", e.tag), {16'h0, bus.q_b}, {16'h0, e.exp});
                    default: check($sformatf("collide#%0d", e.tag), {31'h0, bus.collide}, {16'h0, e.exp});
                endcase
            end
        end
    end

    initial begin : stim
        bus.init = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check("rst_q_a", {16'h0, bus.q_a}, 0);
        check("rst_q_b", {16'h0, bus.q_b}, 0);
        check("rst_collide", {31'h0, bus.collide}, 0);
        check("rst_busy", {31'h0, bus.busy}, 1);

        rst_n = 1'b1;
        n = 0;
        while (bus.busy && n < 100) begin step(); n++; end
        check("busy_len_reset", n, DEPTH);

        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 4'(a), 0, 0, 0, 4'(DEPTH - 1 - a), 0, 0);
            expect_out(0, INIT_VAL, a);
            expect_out(1, INIT_VAL, a);
            step();
        end

        // lane write: zero addr 3, then upper lane only
        drive(1, 3, 16'h0000, 2'b11, 0, 3, 0, 0);
        expect_out(0, RDW_NEW ? 16'h0000 : INIT_VAL, 100);
        expect_out(1, INIT_VAL, 100);
        step();
        drive(1, 3, 16'hBEEF, 2'b10, 0, 3, 0, 0);
        expect_out(0, RDW_NEW ? 16'hBE00 : 16'h0000, 101);
        expect_out(1, 16'h0000, 101);
        step();
        drive(0, 3, 0, 0, 0, 3, 0, 0);
        expect_out(0, 16'hBE00, 102);
        expect_out(1, 16'hBE00, 102);
        step();

        // overlapping dual write: A wins, collide for one cycle
        drive(1, 5, 16'h0011, 2'b01, 1, 5, 16'h0022, 2'b01);
        expect_out(2, 1, 200);
        step();
        drive(0, 5, 0, 0, 0, 5, 0, 0);
        expect_out(0, 16'h0011, 201);
        expect_out(2, 0, 201);
        step();
        // disjoint lanes at one address: both land, no collide
        drive(1, 6, 16'h1111, 2'b01, 1, 6, 16'h2222, 2'b10);
        expect_out(2, 0, 202);
        step();
        drive(0, 6, 0, 0, 0, 5, 0, 0);
        expect_out(0, 16'h2211, 203);
        expect_out(1, 16'h0011, 203);
        expect_out(2, 0, 203);
        step();

        // read during write
        drive(1, 7, 16'h0033, 2'b11, 0, 0, 0, 0);
        step();
        drive(1, 7, 16'h0044, 2'b11, 0, 7, 0, 0);
        expect_out(0, RDW_NEW ? 16'h0044 : 16'h0033, 300);
        expect_out(1, 16'h0033, 300);
        step();
        drive(0, 7, 0, 0, 0, 7, 0, 0);
        expect_out(0, 16'h0044, 301);
        expect_out(1, 16'h0044, 301);
        step();
        repeat (LAT + 1) step();

        // init, write while busy, second init ignored
        bus.init = 1'b1;
        step();
        bus.init = 1'b0;
        check("init_busy", {31'h0, bus.busy}, 1);
        drive(1, 0, 16'h0077, 2'b11, 0, 0, 0, 0);
        n = 0;
        while (bus.busy && n < 100) begin
            bus.init = (n == 5);
            step();
            n++;
            bus.en_a = 1'b0;
        end
        bus.init = 1'b0;
        check("busy_len_init", n, DEPTH);
        drive(0, 0, 0, 0, 0, 3, 0, 0);
        expect_out(0, INIT_VAL, 400);
        expect_out(1, INIT_VAL, 400);
        step();
        repeat (LAT + 1) step();

        // reset in the middle of a clear
        bus.init = 1'b1;
        step();
        bus.init = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, bus.busy}, 1);
        check("midrst_q_a", {16'h0, bus.q_a}, 0);
        step();
        step();
        check("midrst_busy_hold", {31'h0, bus.busy}, 1);
        rst_n = 1'b1;
        n = 0;
        while (bus.busy && n < 100) begin step(); n++; end
        check("busy_len_midrst", n, DEPTH);
        drive(0, 7, 0, 0, 0, 15, 0, 0);
        expect_out(0, INIT_VAL, 500);
        expect_out(1, INIT_VAL, 500);
        step();

        repeat (LAT + 2) step();
        check("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dp_ram_clr.md
DP_RAM_CLR -- requirements
Module: dp_ram_clr

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per word.
REQ-002 SHALL have parameter DEPTH, default 256, words; any value >= 2, not necessarily a power of two; AW = $clog2(DEPTH).
REQ-003 SHALL have parameter LANE_W, default 8, bits per write-enable lane; WIDTH divisible by LANE_W; NL = WIDTH/LANE_W.
REQ-004 SHALL have parameter RDW_NEW, default 0, same-port read-during-write result: 0 = old data, 1 = new data.
REQ-005 SHALL have parameter INIT_VAL, default 0, WIDTH-bit value written by the clear sequence.
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port init, input, 1, one-cycle request to re-run the clear sequence.
REQ-009 SHALL have port busy, output, 1, high while the clear sequence runs.
REQ-010 SHALL have ports addr_a / addr_b, input, AW, port addresses.
REQ-011 SHALL have ports en_a / en_b, input, 1, write enables.
REQ-012 SHALL have ports be_a / be_b, input, NL, lane enables, qualified by en_x.
REQ-013 SHALL have ports d_a / d_b, input, WIDTH, write data.
REQ-014 SHALL have ports q_a / q_b, output, WIDTH, read data.
REQ-015 SHALL have port collide, output, 1, one-cycle pulse on same-address dual write.

Function
REQ-016 SHALL read every cycle on both ports; q_x is valid 1 cycle after addr_x (base latency 1).
REQ-017 SHALL write lane i of word addr_x when en_x && be_x[i] && !busy; other lanes are unchanged.
REQ-018 SHALL return the pre-write word on q_x for a same-port read-during-write if RDW_NEW=0; SHALL return the merged post-write word if RDW_NEW=1.
REQ-019 SHALL return the old word on the reading port for a cross-port read of a word the other port writes that cycle.
REQ-020 SHALL resolve dual writes to the same address lane by lane: port A wins on lanes both enable; B-only lanes take d_b; collide=1 the next cycle iff any lane overlaps.
REQ-021 SHALL ignore writes and read back 0 for addr_x >= DEPTH.
REQ-022 SHALL implement a clear FSM with states IDLE and CLEAR: CLEAR writes INIT_VAL to counter address 0..DEPTH-1, one word per cycle; at DEPTH-1 it goes to IDLE and busy falls the following cycle.
REQ-023 SHALL take init=1 in IDLE to CLEAR with counter=0; SHALL ignore init in CLEAR.
REQ-024 SHALL drop user writes during busy; reads continue and may return partially cleared contents.
REQ-025 SHALL make the clear sequence take exactly DEPTH cycles of busy=1.

Reset
REQ-026 SHALL, on rst_n low, immediately set q_a=0, q_b=0, collide=0, busy=1, FSM=CLEAR, counter=0.
REQ-027 SHALL start clearing from address 0 on the first clk edge after rst_n rises; a reset during CLEAR restarts from address 0.
REQ-028 SHALL NOT reset the storage array; the clear FSM provides initialisation.

Configuration
REQ-029 SHALL, with DP_RAM_CLR_OUTREG_EN defined, add one output register stage on q_a/q_b: latency 2, reset value 0; collide SHALL be delayed identically.
REQ-030 SHALL, without DP_RAM_CLR_OUTREG_EN, keep latency 1 and add no extra stage.

Structure
REQ-031 SHALL have shared package dp_ram_pkg holding the FSM state typedef (IDLE, CLEAR) and the RDW_OLD/RDW_NEW constants.
REQ-032 SHALL place the clear FSM and counter in sub-module dp_ram_clr_seq (outputs busy, clear address, clear write strobe).

Verification
REQ-033 SHALL verify reset then idle: DEPTH=16, release rst_n -> busy high exactly 16 cycles; every address reads INIT_VAL=0xA5.
REQ-034 SHALL verify lane write: WIDTH=16, word 0x0000, A writes 0xBEEF be=2'b10 at addr 3 -> read addr 3 gives 0xBE00 after 1 cycle (2 with OUTREG).
REQ-035 SHALL verify collision: A writes 0x11 and B writes 0x22 at addr 5, both be=1 -> addr 5 = 0x11; collide high exactly one cycle.
REQ-036 SHALL verify read-during-write: addr 7 holds 0x33, A writes 0x44 at addr 7 -> q_a=0x33 (RDW_NEW=0) or 0x44 (RDW_NEW=1); B reading addr 7 that cycle sees 0x33.
REQ-037 SHALL verify reset mid-clear: rst_n low at counter=9 -> busy stays 1; on release, clear restarts at 0 and busy lasts DEPTH cycles.
REQ-038 SHALL verify write during busy: init pulse, then A writes 0x77 at addr 0 while busy -> addr 0 reads INIT_VAL after busy falls.
